cache_refill: RTL and testbench
===============================

Name: cache_refill

Overview:
- Refill controller directly upstream of the cache data, tag and valid BRAM arrays.
- On a miss it invalidates the victim line, fetches one 32-byte line (8 words) from memory as a read burst, and writes each beat into the per-word data bank of the chosen way.
- It writes the tag and sets valid only after all data is written, so a half-filled line can never hit.
- It also forwards each beat to the pipeline for early restart.

Parameters:
- WAYS, 2, number of ways; one data/tag/valid bank set per way.
- WORDS, 8, words per line; one 32-bit data bank per word per way.
- INDEX_W, 7, set index width (128 sets).
- TAG_W, 20, tag width; address split is tag[31:12], index[11:5], offset[4:0].

Ports:
- clk  in  1  single clock for the block and the BRAM write ports.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  miss refill request.
- req_ready  out  1  high only in IDLE.
- req_addr  in  32  miss address; only tag and index are used.
- req_way  in  $clog2(WAYS)  victim way.
- mem_req  out  1  burst read request, held until granted.
- mem_addr  out  32  line-aligned address {tag, index, 5'b0}.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  32  read beat data.
- mem_rlast  in  1  final beat marker.
- data_ena  out  WAYS*WORDS  one-hot data bank enable; bit = way*WORDS + word.
- data_wea  out  4  byte write enable; 4'hF on every refill write.
- data_addr  out  INDEX_W  set index.
- data_din  out  32  data to the data banks.
- tag_ena  out  WAYS  tag write enable, one-hot by way.
- tag_din  out  TAG_W  tag to the tag bank.
- vl_ena  out  WAYS  valid-bit write enable, one-hot by way.
- vl_din  out  1  valid bit value.
- tag_addr, vl_addr  out  INDEX_W  both equal data_addr.
- fwd_valid  out  1  beat forward strobe.
- fwd_word  out  3  word offset of the forwarded beat.
- fwd_data  out  32  forwarded beat data.
- refill_done  out  1  one-cycle pulse at commit.
- refill_err  out  1  one-cycle pulse at commit when the burst was short.

Behaviour:
- FSM states: IDLE, INVAL, REQ, RECV, COMMIT.
  - Held in IDLE while rst=1.
  - Synchronous reset also clears the beat counter, latched address, latched way and error flag.
- Reset values:
  - req_ready=1 (IDLE).
  - All other outputs 0, including every enable, refill_done, refill_err and fwd_valid.
  - While rst=1, all write enables are forced 0 combinationally.
- IDLE:
  - req_ready=1.
  - On req_valid, latch tag, index and way; clear the counter and error flag; go to INVAL.
- INVAL (exactly 1 cycle):
  - vl_ena[way]=1, vl_din=0 at the latched index; go to REQ.
- REQ:
  - mem_req=1 with mem_addr stable.
  - When mem_gnt=1 in a cycle, go to RECV next cycle; mem_req drops that next cycle.
  - Grant in the first REQ cycle is allowed.
- RECV, per cycle with mem_rvalid=1:
  - data_ena[way*WORDS+cnt]=1, data_wea=4'hF, data_din=mem_rdata, same cycle (combinational from the beat).
  - fwd_valid=1, fwd_word=cnt, fwd_data=mem_rdata, same cycle.
  - cnt increments.
- RECV completion:
  - cnt==7 on a valid beat → COMMIT.
  - mem_rlast=1 on a valid beat with cnt<7 → set error flag, go to COMMIT.
  - mem_rlast missing on beat 7 is ignored; beat 7 ends the burst.
  - Beats arriving outside RECV are dropped with no write.
  - Gaps (mem_rvalid=0) stall with no writes.
- COMMIT (exactly 1 cycle):
  - tag_ena[way]=1, tag_din=latched tag.
  - vl_ena[way]=1, vl_din=~error flag.
  - refill_done=1; refill_err=error flag.
  - Next state IDLE.
- Ordering guarantee: valid=1 is written at least one cycle after the last data write, so a same-index read on the next cycle sees consistent data.
- Latency, ideal memory (gnt immediate, 8 back-to-back beats from the cycle after grant): accept edge → INVAL → REQ → 8 RECV cycles → COMMIT = 12 cycles from request accept to refill_done.
- Reset in any state:
  - The next edge returns to IDLE with no further writes.
  - A line caught mid-refill stays invalid (cleared in INVAL).
- Back-to-back requests: a new req_valid is accepted in the IDLE cycle after COMMIT.
- Never touches the llit array or any way other than the latched one.

Test Plan:
- Ideal memory:
  - Stimulus: req_addr=32'hABCDE_0A0 (index 5, tag 20'hABCDE), way 1; beats 0..7 = 32'h1000+i.
  - Required: vl_ena=2'b10 with vl_din=0 in the cycle after acceptance.
  - Required: data_ena bit 8+i with data_din=32'h1000+i in the i-th RECV cycle.
  - Required: commit writes tag 20'hABCDE, valid 1; refill_done exactly 12 cycles after acceptance.
- Stalled memory: mem_gnt delayed 5 cycles, rvalid toggling 1/0 → identical bank contents; mem_req held stable until grant; no writes in gap cycles.
- Short burst: mem_rlast on the 4th beat → banks 0..3 written, then commit with vl_din=0, refill_err=1, refill_done=1.
- Reset mid-RECV after 3 beats: no enables active in the reset cycle or after; req_ready=1 next cycle; valid at that index stays 0.
- Back-to-back: two requests (way 0 index 127, way 1 index 0) issued with req_valid held → second accepted in the cycle after the first refill_done; no cross-way enables.
- Spurious beats: mem_rvalid pulsed in IDLE and REQ → no data_ena and no fwd_valid asserted.

Source files
------------

// File: rtl/cache_refill.sv
// Cache line refill controller: invalidates the victim line, fetches one line as a
// memory read burst, writes each beat into the chosen way's per-word data bank and
// forwards it to the pipeline. Tag and valid are committed only after all data is written.
module cache_refill #(
    parameter int unsigned WAYS    = 2,
    parameter int unsigned WORDS   = 8,
    parameter int unsigned INDEX_W = 7,
    parameter int unsigned TAG_W   = 20,
    localparam int unsigned WayW   = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned CntW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic [WayW-1:0]          req_way,

    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_rlast,

    output logic [WAYS*WORDS-1:0]    data_ena,
    output logic [3:0]               data_wea,
    output logic [INDEX_W-1:0]       data_addr,
    output logic [31:0]              data_din,

    output logic [WAYS-1:0]          tag_ena,
    output logic [INDEX_W-1:0]       tag_addr,
    output logic [TAG_W-1:0]         tag_din,

    output logic [WAYS-1:0]          vl_ena,
    output logic [INDEX_W-1:0]       vl_addr,
    output logic                     vl_din,

    output logic                     fwd_valid,
    output logic [CntW-1:0]          fwd_word,
    output logic [31:0]              fwd_data,

    output logic                     refill_done,
    output logic                     refill_err
);

    localparam int unsigned OffW  = $clog2(WORDS * 4);
    localparam int unsigned BankW = (WAYS * WORDS > 1) ? $clog2(WAYS * WORDS) : 1;
    localparam logic [CntW-1:0] LastWord = CntW'(WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInval,
        StReq,
        StRecv,
        StCommit
    } state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [TAG_W-1:0]    tag_q;
    logic [INDEX_W-1:0]  idx_q;
    logic [WayW-1:0]     way_q;
    logic                err_q;

    logic                beat;
    logic                inval_wr;
    logic                commit_wr;
    logic [WAYS-1:0]     way_oh;
    logic [BankW-1:0]    bank;

    // Line offset bits of the miss address are irrelevant to a whole-line refill.
    logic unused_offset;
    assign unused_offset = ^req_addr[OffW-1:0];

    // Refill sequencer: latches the request, walks INVAL -> REQ -> RECV -> COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
            way_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        tag_q   <= req_addr[31 -: TAG_W];
                        idx_q   <= req_addr[OffW +: INDEX_W];
                        way_q   <= req_way;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= StInval;
                    end
                end
                StInval: state_q <= StReq;
                StReq: begin
                    if (mem_gnt) begin
                        state_q <= StRecv;
                    end
                end
                StRecv: begin
                    if (mem_rvalid) begin
                        cnt_q <= cnt_q + CntW'(1);
                        // The final word always ends the burst; an early rlast marks it short.
                        if (cnt_q == LastWord) begin
                            state_q <= StCommit;
                        end else if (mem_rlast) begin
                            err_q   <= 1'b1;
                            state_q <= StCommit;
                        end
                    end
                end
                StCommit: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Write strobes; reset masks every write port in the same cycle.
    always_comb begin
        beat      = (state_q == StRecv) && mem_rvalid && !rst;
        inval_wr  = (state_q == StInval) && !rst;
        commit_wr = (state_q == StCommit) && !rst;
        way_oh    = WAYS'(1) << way_q;
        bank      = BankW'(way_q) * BankW'(WORDS) + BankW'(cnt_q);
    end

    // Output decode: control from state, data path combinational from the current beat.
    always_comb begin
        req_ready   = (state_q == StIdle);
        mem_req     = (state_q == StReq);
        mem_addr    = {tag_q, idx_q, {OffW{1'b0}}};

        data_ena    = beat ? ((WAYS * WORDS)'(1) << bank) : '0;
        data_wea    = beat ? 4'hF : 4'h0;
        data_din    = beat ? mem_rdata : '0;
        data_addr   = idx_q;

        tag_ena     = commit_wr ? way_oh : '0;
        tag_din     = commit_wr ? tag_q : '0;
        tag_addr    = idx_q;

        vl_ena      = (inval_wr || commit_wr) ? way_oh : '0;
        vl_din      = commit_wr && !err_q;
        vl_addr     = idx_q;

        fwd_valid   = beat;
        fwd_word    = beat ? cnt_q : '0;
        fwd_data    = beat ? mem_rdata : '0;

        refill_done = commit_wr;
        refill_err  = commit_wr && err_q;
    end

endmodule

// File: tb/tb_cache_refill.sv
// Scoreboard bench for cache_refill: drivers push expected bank writes into a queue,
// a negedge monitor pops and compares every write cycle the DUT presents.
module tb_cache_refill;

    localparam int WAYS = 2;
    localparam int WORDS = 8;
    localparam int INDEX_W = 7;
    localparam int TAG_W = 20;

    localparam logic [1:0] KData   = 2'd1;
    localparam logic [1:0] KInval  = 2'd2;
    localparam logic [1:0] KCommit = 2'd3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid;
    logic                    req_ready;
    logic [31:0]             req_addr;
    logic [0:0]              req_way;
    logic                    mem_req;
    logic [31:0]             mem_addr;
    logic                    mem_gnt;
    logic                    mem_rvalid;
    logic [31:0]             mem_rdata;
    logic                    mem_rlast;
    logic [WAYS*WORDS-1:0]   data_ena;
    logic [3:0]              data_wea;
    logic [INDEX_W-1:0]      data_addr;
    logic [31:0]             data_din;
    logic [WAYS-1:0]         tag_ena;
    logic [INDEX_W-1:0]      tag_addr;
    logic [TAG_W-1:0]        tag_din;
    logic [WAYS-1:0]         vl_ena;
    logic [INDEX_W-1:0]      vl_addr;
    logic                    vl_din;
    logic                    fwd_valid;
    logic [2:0]              fwd_word;
    logic [31:0]             fwd_data;
    logic                    refill_done;
    logic                    refill_err;

    cache_refill #(
        .WAYS    (WAYS),
        .WORDS   (WORDS),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_way     (req_way),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_rlast   (mem_rlast),
        .data_ena    (data_ena),
        .data_wea    (data_wea),
        .data_addr   (data_addr),
        .data_din    (data_din),
        .tag_ena     (tag_ena),
        .tag_addr    (tag_addr),
        .tag_din     (tag_din),
        .vl_ena      (vl_ena),
        .vl_addr     (vl_addr),
        .vl_din      (vl_din),
        .fwd_valid   (fwd_valid),
        .fwd_word    (fwd_word),
        .fwd_data    (fwd_data),
        .refill_done (refill_done),
        .refill_err  (refill_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] dena;
        logic [1:0]  vena;
        logic [1:0]  tena;
        logic        vdin;
        logic [19:0] tag;
        logic [6:0]  idx;
        logic [6:0]  tidx;
        logic [6:0]  vidx;
        logic [31:0] din;
        logic [3:0]  wea;
        logic        fv;
        logic [2:0]  word;
        logic [31:0] fwd;
        logic        err;
    } ev_t;

    ev_t sbq[$];
    // Valid-bit contents as written by the DUT; starts at 1 so a missing invalidate shows.
    logic vshadow [WAYS][128] = '{default: 1'b1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected write sequence of one refill: invalidate, nwr data beats, optional commit.
    task automatic expect_refill(input logic [31:0] addr, input int way, input int nwr,
                                 input logic err, input logic [31:0] base, input bit commit);
        ev_t e;
        logic [6:0] idx;
        idx = addr[11:5];
        e = '0;
        e.kind = KInval;
        e.vena = 2'b01 << way;
        e.idx = idx; e.tidx = idx; e.vidx = idx;
        sbq.push_back(e);
        for (int i = 0; i < nwr; i++) begin
            e = '0;
            e.kind = KData;
            e.dena = 16'h0001 << (way * WORDS + i);
            e.idx = idx; e.tidx = idx; e.vidx = idx;
            e.din = base + 32'(i);
            e.wea = 4'hF;
            e.fv = 1'b1;
            e.word = 3'(i);
            e.fwd = base + 32'(i);
            sbq.push_back(e);
        end
        if (commit) begin
            e = '0;
            e.kind = KCommit;
            e.vena = 2'b01 << way;
            e.tena = 2'b01 << way;
            e.vdin = !err;
            e.tag = addr[31:12];
            e.idx = idx; e.tidx = idx; e.vidx = idx;
            e.err = err;
            sbq.push_back(e);
        end
    endtask

    // Monitor: every cycle with any write or forward is one scoreboard event.
    always @(negedge clk) begin
        ev_t a;
        ev_t e;
        if (data_ena != 0 || vl_ena != 0 || tag_ena != 0 || fwd_valid || refill_done
            || refill_err) begin
            a = '0;
            a.kind = refill_done ? KCommit : ((data_ena != 0 || fwd_valid) ? KData : KInval);
            a.dena = data_ena;
            a.vena = vl_ena;
            a.tena = tag_ena;
            a.vdin = (vl_ena != 0) ? vl_din : 1'b0;
            a.tag  = (tag_ena != 0) ? tag_din : '0;
            a.idx  = data_addr;
            a.tidx = tag_addr;
            a.vidx = vl_addr;
            a.din  = (data_ena != 0) ? data_din : '0;
            a.wea  = (data_ena != 0) ? data_wea : '0;
            a.fv   = fwd_valid;
            a.word = fwd_valid ? fwd_word : '0;
            a.fwd  = fwd_valid ? fwd_data : '0;
            a.err  = refill_err;
            for (int w = 0; w < WAYS; w++) begin
                if (vl_ena[w]) vshadow[w][vl_addr] = vl_din;
            end
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got %h expected no write (t=%0t)", a, $time);
            end else begin
                e = sbq.pop_front();
                if (a !== e) begin
                    fails++;
                    $display("FAIL sb_event: got %h expected %h (t=%0t)", a, e, $time);
                end
            end
        end
    end

    task automatic send_req(input logic [31:0] addr, input int way, input bit hold,
                            output int acc_cyc);
        req_addr = addr;
        req_way = 1'(way);
        req_valid = 1'b1;
        for (int n = 0; n < 40 && req_ready !== 1'b1; n++) step();
        chk("req_ready_wait", req_ready, 1);
        step();
        acc_cyc = cyc;
        if (!hold) req_valid = 1'b0;
    endtask

    // Memory model: optional grant delay (with spurious beats), optional gaps, early rlast.
    task automatic serve_mem(input int gnt_dly, input bit gaps, input bit spur, input int last_at,
                             input int nbeats, input logic [31:0] base, input logic [31:0] exp_addr);
        for (int n = 0; n < 40 && mem_req !== 1'b1; n++) step();
        chk("mem_req_wait", mem_req, 1);
        if (mem_req !== 1'b1) return;
        chk("mem_addr", mem_addr, exp_addr);
        for (int d = 0; d < gnt_dly; d++) begin
            mem_rvalid = spur;
            mem_rlast = spur;
            mem_rdata = 32'hBAD0_0000 + 32'(d);
            #1;
            if (spur) chk("spur_req_quiet", {data_ena, fwd_valid}, 0);
            step();
            mem_rvalid = 1'b0;
            mem_rlast = 1'b0;
            chk("mem_req_held", mem_req, 1);
            chk("mem_addr_held", mem_addr, exp_addr);
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("mem_req_drop", mem_req, 0);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && i > 0) begin
                mem_rvalid = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                step();
            end
            mem_rvalid = 1'b1;
            mem_rdata = base + 32'(i);
            mem_rlast = (i == last_at);
            step();
        end
        mem_rvalid = 1'b0;
        mem_rlast = 1'b0;
    endtask

    task automatic wait_done(output int done_cyc);
        for (int n = 0; n < 20 && refill_done !== 1'b1; n++) step();
        chk("refill_done", refill_done, 1);
        done_cyc = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc;
        int dc;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_way = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
        repeat (3) step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_enables", {data_ena, vl_ena, tag_ena, data_wea}, 0);
        chk("rst_strobes", {refill_done, refill_err, fwd_valid}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        step();

        // Ideal memory: index 5, tag ABCDE, way 1; 12 cycles accept..commit inclusive,
        // i.e. refill_done appears 10 edges after the accepting edge.
        expect_refill(32'hABCD_E0A0, 1, 8, 1'b0, 32'h1000, 1'b1);
        send_req(32'hABCD_E0A0, 1, 1'b0, acc);
        chk("inval_vl_ena", vl_ena, 2'b10);
        chk("inval_vl_din", vl_din, 0);
        chk("inval_vl_addr", vl_addr, 7'd5);
        serve_mem(0, 1'b0, 1'b0, 7, 8, 32'h1000, 32'hABCD_E0A0);
        wait_done(dc);
        chk("latency", dc - acc, 10);
        chk("commit_tag", tag_din, 20'hABCDE);
        chk("commit_vl_din", vl_din, 1);
        step();
        chk("idle_ready", req_ready, 1);
        chk("drain_ideal", sbq.size(), 0);

        // Stalled memory, same line via an unaligned address, no rlast at all.
        expect_refill(32'hABCD_E0A0, 1, 8, 1'b0, 32'h1000, 1'b1);
        send_req(32'hABCD_E0B4, 1, 1'b0, acc);
        serve_mem(5, 1'b1, 1'b0, -1, 8, 32'h1000, 32'hABCD_E0A0);
        wait_done(dc);
        chk("stall_err", refill_err, 0);
        step();
        chk("drain_stall", sbq.size(), 0);

        // Short burst: rlast on the 4th beat.
        expect_refill(32'h1234_5660, 0, 4, 1'b1, 32'h2000, 1'b1);
        send_req(32'h1234_5660, 0, 1'b0, acc);
        serve_mem(1, 1'b0, 1'b0, 3, 4, 32'h2000, 32'h1234_5660);
        wait_done(dc);
        chk("short_err", refill_err, 1);
        chk("short_vl_din", vl_din, 0);
        step();
        chk("drain_short", sbq.size(), 0);

        // Reset after 3 beats of a refill at index 10, way 0.
        expect_refill(32'h5555_5140, 0, 3, 1'b0, 32'h5000, 1'b0);
        send_req(32'h5555_5140, 0, 1'b0, acc);
        serve_mem(0, 1'b0, 1'b0, -1, 3, 32'h5000, 32'h5555_5140);
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5000_0003;
        #1;
        chk("rst_gate", {data_ena, vl_ena, tag_ena, fwd_valid, refill_done}, 0);
        step();
        rst = 1'b0;
        mem_rvalid = 1'b0;
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_mem_req", mem_req, 0);
        repeat (3) step();
        chk("rst_valid_stays_0", vshadow[0][10], 0);
        chk("drain_rst", sbq.size(), 0);

        // Back-to-back with req_valid held: way 0 index 127, then way 1 index 0.
        expect_refill(32'h1111_1FE0, 0, 8, 1'b0, 32'h3000, 1'b1);
        expect_refill(32'h2222_2000, 1, 8, 1'b0, 32'h4000, 1'b1);
        send_req(32'h1111_1FE0, 0, 1'b1, acc);
        req_addr = 32'h2222_2000;
        req_way = 1'b1;
        serve_mem(0, 1'b0, 1'b0, 7, 8, 32'h3000, 32'h1111_1FE0);
        wait_done(dc);
        step();
        chk("b2b_idle_ready", req_ready, 1);
        step();
        chk("b2b_accepted", req_ready, 0);
        chk("b2b_inval_way1", vl_ena, 2'b10);
        req_valid = 1'b0;
        serve_mem(2, 1'b1, 1'b0, 7, 8, 32'h4000, 32'h2222_2000);
        wait_done(dc);
        step();
        chk("drain_b2b", sbq.size(), 0);

        // Spurious beats in IDLE and in REQ must not write or forward.
        mem_rvalid = 1'b1;
        mem_rlast = 1'b1;
        mem_rdata = 32'hFEED_0000;
        #1;
        chk("spur_idle_quiet", {data_ena, fwd_valid}, 0);
        step();
        mem_rvalid = 1'b0;
        mem_rlast = 1'b0;
        expect_refill(32'hCAFE_F3E0, 0, 8, 1'b0, 32'h6000, 1'b1);
        send_req(32'hCAFE_F3E0, 0, 1'b0, acc);
        serve_mem(3, 1'b0, 1'b1, 7, 8, 32'h6000, 32'hCAFE_F3E0);
        wait_done(dc);
        chk("spur_err", refill_err, 0);
        step();
        step();
        chk("drain_spur", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
